ml2kl_bridge: RTL and testbench
===============================

Name: ml2kl_bridge

Overview:
- MLink B-side (responder) to KLink A-side (initiator) bridge; the counterpart of the KLink-to-MLink bridge on the far end of the link.
- Sits between the KLink-facing ports of an ml_xcvr instance with INITIAL_ROLE(1) and a KLink target port (memory/peripheral crossbar).
- Converts mask-less, LSB-justified MLink requests into lane-aligned KLink requests with byte masks, and tracks outstanding requests in order.
- Converts KLink responses back into LSB-justified MLink responses. Malformed requests are answered locally with an error response.

Parameters:
REQ_DEPTH, 4, inbound request FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, tracker entries: requests issued or locally answered, awaiting response (power of 2, >=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
xr_rx_addr  input  32  request address from transceiver
xr_rx_den  input  1  1 = write (data present)
xr_rx_data  input  64  write data, LSB-justified
xr_rx_size  input  3  log2 bytes (0..3 legal)
xr_rx_id  input  5  requester id
xr_rx_valid  input  1  request valid
xr_rx_ready  output  1  request accept
xr_tx_addr  output  32  response address (original request address)
xr_tx_den  output  1  1 = read data present
xr_tx_data  output  64  read data, LSB-justified, zero above size
xr_tx_size  output  3  response size
xr_tx_id  output  5  destination id
xr_tx_valid  output  1  response valid
xr_tx_ready  input  1  response accept
kl_req_addr  output  32  KLink request address
kl_req_wen  output  1  write enable
kl_req_wdata  output  64  lane-aligned write data
kl_req_wmask  output  8  byte mask
kl_req_size  output  3  size
kl_req_srcid  output  5  source id
kl_req_valid  output  1  request valid
kl_req_ready  input  1  request accept
kl_resp_rdata  input  64  lane-aligned read data
kl_resp_ren  input  1  1 = read response
kl_resp_size  input  3  size (ignored; tracker is authoritative)
kl_resp_dstid  input  5  id (ignored; tracker is authoritative)
kl_resp_valid  input  1  response valid
kl_resp_ready  output  1  response accept

Behaviour:
- Handshake: a transfer occurs when valid && ready are both high on a rising clk edge. Valid is held and payload is stable until accepted. No combinational valid-to-valid path.
- Reset: all FIFOs/tracker empty, counters 0; xr_rx_ready=0 while rst is high, then 1 once the FIFO has space; xr_tx_valid=0, kl_req_valid=0, kl_resp_ready=0; all data outputs 0. Reset asserted mid-transfer discards all state, with no partial responses afterwards.
- Request FIFO: xr_rx_ready = !full. Simultaneous push and pop while full is not allowed (ready is already low); push and pop in the same cycle at any other occupancy is legal. Read/write pointers wrap modulo REQ_DEPTH.
- Issue stage (FIFO head, registered outputs):
  - Legal if size<=3 and addr[2:0] is a multiple of 2^size.
  - Legal request: kl_req_wmask = ((1<<2^size)-1) << addr[2:0]; kl_req_wdata = xr_rx_data << (8*addr[2:0]); addr, size and id passed through; wen = den.
  - Illegal request: never sent to KLink; marked local-error in the tracker.
  - Head is popped only if tracker count < MAX_OUTSTANDING and (illegal, or the KLink output register is empty or accepted this cycle).
  - Latency: request accepted at cycle N into an empty FIFO gives kl_req_valid at N+1.
- Tracker: in-order queue holding addr, size, id, is_write, local flag; written at issue/pop. KLink returns exactly one response per request, in order; ren=0 for writes.
- Response stage (1-entry output register):
  - Head local: emits tx with den=0, data=64'hFFFF_FFFF_FFFF_FFFF, original addr/size/id.
  - Head non-local: kl_resp_ready = head valid && non-local && (output register empty or xr_tx_ready). On handshake: data = (rdata >> 8*addr[2:0]) masked to 2^size bytes; den = kl_resp_ren.
  - Tracker entry retires when it is loaded into the output register.
  - Latency: KLink response at cycle M gives xr_tx_valid at M+1. Throughput is 1 per cycle both ways.
- Boundaries:
  - Tracker full: stall issue, but keep accepting into the FIFO until full.
  - A KLink response arriving with the tracker empty is a protocol violation; kl_resp_ready stays 0.
  - Simultaneous tracker retire and new issue when full: the issue proceeds.

Test Plan:
- Read 4B at 0x1000_0004, id 3; KLink returns rdata 0xDEADBEEF_00000000 -> kl_req_wmask=0xF0, kl_req_wen=0; xr_tx den=1, data=0x00000000_DEADBEEF, addr 0x1000_0004, id 3, one cycle after the KLink response.
- Write 1B data 0xA5 to addr 0x...03 -> kl_req_wmask=0x08, wdata=0x00000000_A5000000; KLink ren=0 response -> xr_tx den=0, id preserved.
- Misaligned 4B at addr 0x2 followed by legal 8B read at 0x8 -> first tx: den=0, data all-ones, no KLink request; second returns normally, in order.
- Hold kl_resp_valid=0 and issue 10 back-to-back reads -> exactly MAX_OUTSTANDING=4 KLink requests plus REQ_DEPTH=4 buffered, then xr_rx_ready=0; releasing responses drains all 10 in order.
- xr_tx_ready held low for 5 cycles with 3 responses pending -> tx payload stable, kl_resp_ready=0 once the register is full, no loss or duplication.
- Assert rst with 2 requests outstanding -> all valids 0 next cycle, no stale responses after reset.

Source files
------------

// File: rtl/ml2kl_bridge.sv
// MLink responder to KLink initiator bridge: buffers LSB-justified requests, lane-aligns them
// for KLink, tracks them in order and returns LSB-justified responses (local errors for bad requests).
module ml2kl_bridge #(
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] xr_rx_addr,
    input  logic        xr_rx_den,
    input  logic [63:0] xr_rx_data,
    input  logic [2:0]  xr_rx_size,
    input  logic [4:0]  xr_rx_id,
    input  logic        xr_rx_valid,
    output logic        xr_rx_ready,
    output logic [31:0] xr_tx_addr,
    output logic        xr_tx_den,
    output logic [63:0] xr_tx_data,
    output logic [2:0]  xr_tx_size,
    output logic [4:0]  xr_tx_id,
    output logic        xr_tx_valid,
    input  logic        xr_tx_ready,
    output logic [31:0] kl_req_addr,
    output logic        kl_req_wen,
    output logic [63:0] kl_req_wdata,
    output logic [7:0]  kl_req_wmask,
    output logic [2:0]  kl_req_size,
    output logic [4:0]  kl_req_srcid,
    output logic        kl_req_valid,
    input  logic        kl_req_ready,
    input  logic [63:0] kl_resp_rdata,
    input  logic        kl_resp_ren,
    input  logic [2:0]  kl_resp_size,
    input  logic [4:0]  kl_resp_dstid,
    input  logic        kl_resp_valid,
    output logic        kl_resp_ready
);

    localparam int RPW = $clog2(REQ_DEPTH);
    localparam int RCW = $clog2(REQ_DEPTH + 1);
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic        den;
        logic [63:0] data;
        logic [2:0]  size;
        logic [4:0]  id;
    } req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [4:0]  id;
        logic        is_write;
        logic        loc_err;
    } trk_t;

    function automatic logic [2:0] align_bits(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [TPW-1:0] trk_next(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    req_t           fifo_mem_q [REQ_DEPTH];
    req_t           fifo_mem_d [REQ_DEPTH];
    logic [RPW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [RCW-1:0] fifo_cnt_q, fifo_cnt_d;

    trk_t           trk_mem_q [MAX_OUTSTANDING];
    trk_t           trk_mem_d [MAX_OUTSTANDING];
    logic [TPW-1:0] trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
    logic [TCW-1:0] trk_cnt_q, trk_cnt_d;

    logic        kl_vld_q, kl_vld_d, kl_wen_q, kl_wen_d;
    logic [31:0] kl_addr_q, kl_addr_d;
    logic [63:0] kl_wdata_q, kl_wdata_d;
    logic [7:0]  kl_wmask_q, kl_wmask_d;
    logic [2:0]  kl_size_q, kl_size_d;
    logic [4:0]  kl_srcid_q, kl_srcid_d;

    logic        tx_vld_q, tx_vld_d, tx_den_q, tx_den_d;
    logic [31:0] tx_addr_q, tx_addr_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic [2:0]  tx_size_q, tx_size_d;
    logic [4:0]  tx_id_q, tx_id_d;

    logic fifo_full, rx_push, head_vld, head_legal, kl_free, trk_has_space, issue_pop, kl_load;
    logic trk_vld, tx_free, resp_rdy, retire;
    req_t rx_req, head;
    trk_t trk_head;
    logic unused_inputs;

    assign unused_inputs = ^{kl_resp_size, kl_resp_dstid, trk_head.is_write};

    assign fifo_full   = (fifo_cnt_q == RCW'(REQ_DEPTH));
    assign xr_rx_ready = !rst && !fifo_full;
    assign rx_push     = xr_rx_valid && xr_rx_ready;
    assign rx_req      = '{addr: xr_rx_addr, den: xr_rx_den, data: xr_rx_data,
                           size: xr_rx_size, id: xr_rx_id};

    // An empty FIFO lets the incoming request reach the issue stage in the same cycle.
    assign head       = (fifo_cnt_q == '0) ? rx_req : fifo_mem_q[fifo_rd_q];
    assign head_vld   = (fifo_cnt_q != '0) || rx_push;
    assign head_legal = !head.size[2] && ((head.addr[2:0] & align_bits(head.size[1:0])) == 3'b000);

    assign trk_vld       = (trk_cnt_q != '0);
    assign trk_head      = trk_mem_q[trk_rd_q];
    assign tx_free       = !tx_vld_q || xr_tx_ready;
    assign resp_rdy      = trk_vld && !trk_head.loc_err && tx_free;
    assign kl_resp_ready = !rst && resp_rdy;
    assign retire        = trk_vld && tx_free && (trk_head.loc_err || kl_resp_valid);

    // A retiring entry frees its slot in time for a same-cycle issue.
    assign kl_free       = !kl_vld_q || kl_req_ready;
    assign trk_has_space = (trk_cnt_q != TCW'(MAX_OUTSTANDING)) || retire;
    assign issue_pop     = head_vld && trk_has_space && (!head_legal || kl_free);
    assign kl_load       = issue_pop && head_legal;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (rx_push) begin
            fifo_mem_d[fifo_wr_q] = rx_req;
            fifo_wr_d             = fifo_wr_q + 1'b1;
        end
        if (issue_pop) fifo_rd_d = fifo_rd_q + 1'b1;
        case ({rx_push, issue_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        trk_mem_d = trk_mem_q;
        trk_wr_d  = trk_wr_q;
        trk_rd_d  = trk_rd_q;
        trk_cnt_d = trk_cnt_q;
        if (issue_pop) begin
            trk_mem_d[trk_wr_q] = '{addr: head.addr, size: head.size, id: head.id,
                                    is_write: head.den, loc_err: !head_legal};
            trk_wr_d            = trk_next(trk_wr_q);
        end
        if (retire) trk_rd_d = trk_next(trk_rd_q);
        case ({issue_pop, retire})
            2'b10:   trk_cnt_d = trk_cnt_q + 1'b1;
            2'b01:   trk_cnt_d = trk_cnt_q - 1'b1;
            default: trk_cnt_d = trk_cnt_q;
        endcase
    end

    always_comb begin
        kl_vld_d   = kl_vld_q;
        kl_addr_d  = kl_addr_q;
        kl_wen_d   = kl_wen_q;
        kl_wdata_d = kl_wdata_q;
        kl_wmask_d = kl_wmask_q;
        kl_size_d  = kl_size_q;
        kl_srcid_d = kl_srcid_q;
        if (kl_load) begin
            kl_vld_d   = 1'b1;
            kl_addr_d  = head.addr;
            kl_wen_d   = head.den;
            kl_wdata_d = head.data << {head.addr[2:0], 3'b000};
            kl_wmask_d = lane_mask(head.size[1:0], head.addr[2:0]);
            kl_size_d  = head.size;
            kl_srcid_d = head.id;
        end else if (kl_req_ready) begin
            kl_vld_d = 1'b0;
        end
    end

    always_comb begin
        tx_vld_d  = tx_vld_q;
        tx_addr_d = tx_addr_q;
        tx_den_d  = tx_den_q;
        tx_data_d = tx_data_q;
        tx_size_d = tx_size_q;
        tx_id_d   = tx_id_q;
        if (retire) begin
            tx_vld_d  = 1'b1;
            tx_addr_d = trk_head.addr;
            tx_size_d = trk_head.size;
            tx_id_d   = trk_head.id;
            if (trk_head.loc_err) begin
                tx_den_d  = 1'b0;
                tx_data_d = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                tx_den_d  = kl_resp_ren;
                tx_data_d = (kl_resp_rdata >> {trk_head.addr[2:0], 3'b000})
                            & size_mask(trk_head.size[1:0]);
            end
        end else if (xr_tx_ready) begin
            tx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            trk_wr_q   <= '0;
            trk_rd_q   <= '0;
            trk_cnt_q  <= '0;
            kl_vld_q   <= 1'b0;
            kl_addr_q  <= '0;
            kl_wen_q   <= 1'b0;
            kl_wdata_q <= '0;
            kl_wmask_q <= '0;
            kl_size_q  <= '0;
            kl_srcid_q <= '0;
            tx_vld_q   <= 1'b0;
            tx_addr_q  <= '0;
            tx_den_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_size_q  <= '0;
            tx_id_q    <= '0;
        end else begin
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            trk_wr_q   <= trk_wr_d;
            trk_rd_q   <= trk_rd_d;
            trk_cnt_q  <= trk_cnt_d;
            kl_vld_q   <= kl_vld_d;
            kl_addr_q  <= kl_addr_d;
            kl_wen_q   <= kl_wen_d;
            kl_wdata_q <= kl_wdata_d;
            kl_wmask_q <= kl_wmask_d;
            kl_size_q  <= kl_size_d;
            kl_srcid_q <= kl_srcid_d;
            tx_vld_q   <= tx_vld_d;
            tx_addr_q  <= tx_addr_d;
            tx_den_q   <= tx_den_d;
            tx_data_q  <= tx_data_d;
            tx_size_q  <= tx_size_d;
            tx_id_q    <= tx_id_d;
        end
    end

    // Storage arrays carry no reset; the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
        trk_mem_q  <= trk_mem_d;
    end

    assign kl_req_valid = kl_vld_q;
    assign kl_req_addr  = kl_addr_q;
    assign kl_req_wen   = kl_wen_q;
    assign kl_req_wdata = kl_wdata_q;
    assign kl_req_wmask = kl_wmask_q;
    assign kl_req_size  = kl_size_q;
    assign kl_req_srcid = kl_srcid_q;

    assign xr_tx_valid = tx_vld_q;
    assign xr_tx_addr  = tx_addr_q;
    assign xr_tx_den   = tx_den_q;
    assign xr_tx_data  = tx_data_q;
    assign xr_tx_size  = tx_size_q;
    assign xr_tx_id    = tx_id_q;

endmodule

// File: tb/tb_ml2kl_bridge.sv
// Randomized bench for ml2kl_bridge: drives MLink requests, acts as the KLink target and
// scores both sides against a queue-based model of the bridge's transaction rules.
module tb_ml2kl_bridge;

    localparam int REQ_DEPTH = 4;
    localparam int MAX_OUT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] xr_rx_addr = '0;
    logic        xr_rx_den = 1'b0;
    logic [63:0] xr_rx_data = '0;
    logic [2:0]  xr_rx_size = '0;
    logic [4:0]  xr_rx_id = '0;
    logic        xr_rx_valid = 1'b0;
    logic        xr_rx_ready;
    logic [31:0] xr_tx_addr;
    logic        xr_tx_den;
    logic [63:0] xr_tx_data;
    logic [2:0]  xr_tx_size;
    logic [4:0]  xr_tx_id;
    logic        xr_tx_valid;
    logic        xr_tx_ready = 1'b0;
    logic [31:0] kl_req_addr;
    logic        kl_req_wen;
    logic [63:0] kl_req_wdata;
    logic [7:0]  kl_req_wmask;
    logic [2:0]  kl_req_size;
    logic [4:0]  kl_req_srcid;
    logic        kl_req_valid;
    logic        kl_req_ready = 1'b0;
    logic [63:0] kl_resp_rdata = '0;
    logic        kl_resp_ren = 1'b0;
    logic [2:0]  kl_resp_size = '0;
    logic [4:0]  kl_resp_dstid = '0;
    logic        kl_resp_valid = 1'b0;
    logic        kl_resp_ready;

    always #5 clk = ~clk;

    ml2kl_bridge #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .xr_rx_addr(xr_rx_addr), .xr_rx_den(xr_rx_den), .xr_rx_data(xr_rx_data),
        .xr_rx_size(xr_rx_size), .xr_rx_id(xr_rx_id), .xr_rx_valid(xr_rx_valid),
        .xr_rx_ready(xr_rx_ready),
        .xr_tx_addr(xr_tx_addr), .xr_tx_den(xr_tx_den), .xr_tx_data(xr_tx_data),
        .xr_tx_size(xr_tx_size), .xr_tx_id(xr_tx_id), .xr_tx_valid(xr_tx_valid),
        .xr_tx_ready(xr_tx_ready),
        .kl_req_addr(kl_req_addr), .kl_req_wen(kl_req_wen), .kl_req_wdata(kl_req_wdata),
        .kl_req_wmask(kl_req_wmask), .kl_req_size(kl_req_size), .kl_req_srcid(kl_req_srcid),
        .kl_req_valid(kl_req_valid), .kl_req_ready(kl_req_ready),
        .kl_resp_rdata(kl_resp_rdata), .kl_resp_ren(kl_resp_ren), .kl_resp_size(kl_resp_size),
        .kl_resp_dstid(kl_resp_dstid), .kl_resp_valid(kl_resp_valid),
        .kl_resp_ready(kl_resp_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic        den;
        logic [63:0] data;
        logic [2:0]  size;
        logic [4:0]  id;
    } req_s;

    req_s        stim_q[$];
    req_s        ord_q[$];
    req_s        kl_exp_q[$];
    logic        kl_pend_q[$];
    logic [63:0] rsp_data_q[$];
    logic        rsp_ren_q[$];
    logic [63:0] tx_data_log[$];
    int          tx_den_log[$];
    int          tx_id_log[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rx_hs = 0, n_kl_hs = 0, n_tx_hs = 0;
    int last_rx_cyc = 0, last_kl_cyc = 0, last_rsp_cyc = 0, last_tx_cyc = 0;
    int rx_pct = 100, kl_rdy_pct = 100, tx_rdy_pct = 100, rsp_pct = 100;
    bit resp_en = 1'b1;
    bit use_fixed = 1'b0;
    logic [63:0] fixed_rdata = '0;
    bit rx_hs = 1'b0, rsp_hs = 1'b0, prev_tx_stall = 1'b0;
    logic [63:0] prev_tx_data;
    logic [40:0] prev_tx_meta;
    logic [7:0]  last_wmask;
    logic [63:0] last_wdata, last_tx_data;
    logic        last_kl_wen, last_tx_den;
    logic [31:0] last_tx_addr;
    logic [4:0]  last_tx_id;
    req_s        cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input req_s r);
        int nb;
        if (r.size > 3) return 1'b0;
        nb = 1 << r.size;
        return (r.addr % nb) == 0;
    endfunction

    function automatic logic [63:0] bytes_mask(input int sz);
        if (sz >= 3) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (64'd1 << (8 << sz)) - 64'd1;
    endfunction

    function automatic logic [7:0] exp_wmask(input req_s r);
        logic [15:0] m;
        m = ((16'd1 << (1 << r.size)) - 16'd1) << r.addr[2:0];
        return m[7:0];
    endfunction

    function automatic req_s mk(input logic [31:0] a, input logic d, input logic [63:0] dat,
                                input logic [2:0] s, input logic [4:0] i);
        req_s r;
        r.addr = a; r.den = d; r.data = dat; r.size = s; r.id = i;
        return r;
    endfunction

    task automatic step();
        req_s e;
        logic [63:0] exp_data;
        logic        exp_den;
        @(negedge clk);
        if (rx_hs) xr_rx_valid = 1'b0;
        if (rsp_hs) kl_resp_valid = 1'b0;
        if (!xr_rx_valid && stim_q.size() > 0 && $urandom_range(99) < rx_pct) begin
            e = stim_q.pop_front();
            xr_rx_addr = e.addr; xr_rx_den = e.den; xr_rx_data = e.data;
            xr_rx_size = e.size; xr_rx_id = e.id; xr_rx_valid = 1'b1;
        end
        if (!kl_resp_valid && resp_en && kl_pend_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            kl_resp_ren   = !kl_pend_q.pop_front();
            kl_resp_rdata = use_fixed ? fixed_rdata : {$urandom, $urandom};
            kl_resp_size  = 3'($urandom);
            kl_resp_dstid = 5'($urandom);
            kl_resp_valid = 1'b1;
        end
        kl_req_ready = ($urandom_range(99) < kl_rdy_pct);
        xr_tx_ready  = ($urandom_range(99) < tx_rdy_pct);
        #1;
        cyc++;
        if (prev_tx_stall) begin
            chk("tx_hold_vld", 64'(xr_tx_valid), 64'd1);
            chk("tx_hold_data", xr_tx_data, prev_tx_data);
            chk("tx_hold_meta", 64'({xr_tx_addr, xr_tx_den, xr_tx_size, xr_tx_id}), 64'(prev_tx_meta));
        end
        if (rsp_hs) chk("tx_lat", 64'(xr_tx_valid), 64'd1);

        rx_hs = xr_rx_valid && xr_rx_ready;
        if (rx_hs) begin
            cur = mk(xr_rx_addr, xr_rx_den, xr_rx_data, xr_rx_size, xr_rx_id);
            ord_q.push_back(cur);
            if (is_legal(cur)) kl_exp_q.push_back(cur);
            n_rx_hs++; last_rx_cyc = cyc;
        end
        if (kl_req_valid && kl_req_ready) begin
            n_kl_hs++; last_kl_cyc = cyc;
            last_wmask = kl_req_wmask; last_wdata = kl_req_wdata; last_kl_wen = kl_req_wen;
            if (kl_exp_q.size() == 0) begin
                chk("kl_unexpected", 64'd1, 64'd0);
            end else begin
                e = kl_exp_q.pop_front();
                chk("kl_addr", 64'(kl_req_addr), 64'(e.addr));
                chk("kl_wen", 64'(kl_req_wen), 64'(e.den));
                chk("kl_wmask", 64'(kl_req_wmask), 64'(exp_wmask(e)));
                chk("kl_wdata", kl_req_wdata, e.data << (8 * e.addr[2:0]));
                chk("kl_size", 64'(kl_req_size), 64'(e.size));
                chk("kl_srcid", 64'(kl_req_srcid), 64'(e.id));
                kl_pend_q.push_back(e.den);
            end
        end
        rsp_hs = kl_resp_valid && kl_resp_ready;
        if (rsp_hs) begin
            rsp_data_q.push_back(kl_resp_rdata);
            rsp_ren_q.push_back(kl_resp_ren);
            last_rsp_cyc = cyc;
        end
        if (xr_tx_valid && xr_tx_ready) begin
            n_tx_hs++; last_tx_cyc = cyc;
            last_tx_data = xr_tx_data; last_tx_den = xr_tx_den;
            last_tx_addr = xr_tx_addr; last_tx_id = xr_tx_id;
            tx_data_log.push_back(xr_tx_data);
            tx_den_log.push_back(int'(xr_tx_den));
            tx_id_log.push_back(int'(xr_tx_id));
            if (ord_q.size() == 0) begin
                chk("tx_unexpected", 64'd1, 64'd0);
            end else begin
                e = ord_q.pop_front();
                exp_data = 64'hFFFF_FFFF_FFFF_FFFF;
                exp_den  = 1'b0;
                if (is_legal(e)) begin
                    if (rsp_data_q.size() == 0) begin
                        chk("tx_before_resp", 64'd1, 64'd0);
                    end else begin
                        exp_data = (rsp_data_q.pop_front() >> (8 * e.addr[2:0])) & bytes_mask(e.size);
                        exp_den  = rsp_ren_q.pop_front();
                    end
                end
                chk("tx_addr", 64'(xr_tx_addr), 64'(e.addr));
                chk("tx_size", 64'(xr_tx_size), 64'(e.size));
                chk("tx_id", 64'(xr_tx_id), 64'(e.id));
                chk("tx_den", 64'(xr_tx_den), 64'(exp_den));
                chk("tx_data", xr_tx_data, exp_data);
            end
        end
        prev_tx_stall = xr_tx_valid && !xr_tx_ready;
        prev_tx_data  = xr_tx_data;
        prev_tx_meta  = {xr_tx_addr, xr_tx_den, xr_tx_size, xr_tx_id};
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || ord_q.size() > 0 || (xr_rx_valid && !rx_hs)) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(stim_q.size() + ord_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        xr_rx_valid = 1'b0;
        kl_resp_valid = 1'b0;
        #1;
        chk("rst_rx_ready", 64'(xr_rx_ready), 64'd0);
        @(negedge clk);
        chk("rst_kl_valid", 64'(kl_req_valid), 64'd0);
        chk("rst_tx_valid", 64'(xr_tx_valid), 64'd0);
        chk("rst_resp_ready", 64'(kl_resp_ready), 64'd0);
        chk("rst_kl_wdata", kl_req_wdata, 64'd0);
        chk("rst_kl_wmask", 64'(kl_req_wmask), 64'd0);
        chk("rst_tx_data", xr_tx_data, 64'd0);
        rst = 1'b0;
        stim_q.delete(); ord_q.delete(); kl_exp_q.delete(); kl_pend_q.delete();
        rsp_data_q.delete(); rsp_ren_q.delete();
        rx_hs = 1'b0; rsp_hs = 1'b0; prev_tx_stall = 1'b0;
        #1;
        chk("rst_rx_ready_after", 64'(xr_rx_ready), 64'd1);
    endtask

    initial begin
        int k0, r0, t0, sz;
        logic [31:0] a;
        do_reset();

        // Aligned 4-byte read in the upper lane
        use_fixed = 1'b1;
        fixed_rdata = 64'hDEAD_BEEF_0000_0000;
        stim_q.push_back(mk(32'h1000_0004, 1'b0, 64'd0, 3'd2, 5'd3));
        drain("t1_drain", 50);
        chk("t1_wmask", 64'(last_wmask), 64'hF0);
        chk("t1_wen", 64'(last_kl_wen), 64'd0);
        chk("t1_req_lat", 64'(last_kl_cyc - last_rx_cyc), 64'd1);
        chk("t1_data", last_tx_data, 64'h0000_0000_DEAD_BEEF);
        chk("t1_den", 64'(last_tx_den), 64'd1);
        chk("t1_addr", 64'(last_tx_addr), 64'h1000_0004);
        chk("t1_id", 64'(last_tx_id), 64'd3);
        chk("t1_rsp_lat", 64'(last_tx_cyc - last_rsp_cyc), 64'd1);
        use_fixed = 1'b0;

        // Single-byte write at offset 3
        stim_q.push_back(mk(32'h4000_0003, 1'b1, 64'hA5, 3'd0, 5'd7));
        drain("t2_drain", 50);
        chk("t2_wmask", 64'(last_wmask), 64'h08);
        chk("t2_wdata", last_wdata, 64'h0000_0000_A500_0000);
        chk("t2_den", 64'(last_tx_den), 64'd0);
        chk("t2_id", 64'(last_tx_id), 64'd7);

        // Misaligned request answered locally, followed by a normal read
        tx_data_log.delete(); tx_den_log.delete(); tx_id_log.delete();
        k0 = n_kl_hs;
        stim_q.push_back(mk(32'h0000_0002, 1'b0, 64'd0, 3'd2, 5'd1));
        stim_q.push_back(mk(32'h0000_0008, 1'b0, 64'd0, 3'd3, 5'd2));
        drain("t3_drain", 60);
        chk("t3_kl_cnt", 64'(n_kl_hs - k0), 64'd1);
        chk("t3_tx_cnt", 64'(tx_data_log.size()), 64'd2);
        chk("t3_err_den", 64'(tx_den_log[0]), 64'd0);
        chk("t3_err_data", tx_data_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_err_id", 64'(tx_id_log[0]), 64'd1);
        chk("t3_ord_id", 64'(tx_id_log[1]), 64'd2);

        // Responses withheld: tracker then FIFO fill up
        resp_en = 1'b0;
        k0 = n_kl_hs; r0 = n_rx_hs; t0 = n_tx_hs;
        for (int i = 0; i < 10; i++)
            stim_q.push_back(mk(32'h2000_0000 + 32'(8 * i), 1'b0, 64'd0, 3'd2, 5'(i)));
        repeat (30) step();
        chk("t4_kl_cnt", 64'(n_kl_hs - k0), 64'(MAX_OUT));
        chk("t4_rx_cnt", 64'(n_rx_hs - r0), 64'(MAX_OUT + REQ_DEPTH));
        chk("t4_rx_ready", 64'(xr_rx_ready), 64'd0);
        resp_en = 1'b1;
        drain("t4_drain", 200);
        chk("t4_tx_cnt", 64'(n_tx_hs - t0), 64'd10);

        // MLink response back-pressure
        tx_rdy_pct = 0;
        t0 = n_tx_hs;
        for (int i = 0; i < 3; i++)
            stim_q.push_back(mk(32'h3000_0010 + 32'(4 * i), 1'b0, 64'd0, 3'd2, 5'(20 + i)));
        repeat (12) step();
        chk("t5_tx_valid", 64'(xr_tx_valid), 64'd1);
        chk("t5_resp_ready", 64'(kl_resp_ready), 64'd0);
        tx_rdy_pct = 100;
        drain("t5_drain", 100);
        chk("t5_tx_cnt", 64'(n_tx_hs - t0), 64'd3);

        // Randomized traffic with random back-pressure on every interface
        rx_pct = 60; kl_rdy_pct = 70; tx_rdy_pct = 70; rsp_pct = 60;
        for (int i = 0; i < 400; i++) begin
            sz = ($urandom_range(9) == 0) ? int'($urandom_range(7, 4)) : int'($urandom_range(3));
            a = $urandom;
            if (sz <= 3 && $urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            stim_q.push_back(mk(a, 1'($urandom), {$urandom, $urandom} & bytes_mask(sz),
                                3'(sz), 5'($urandom)));
        end
        drain("rand_drain", 20000);
        rx_pct = 100; kl_rdy_pct = 100; tx_rdy_pct = 100; rsp_pct = 100;

        // Reset with requests outstanding
        resp_en = 1'b0;
        stim_q.push_back(mk(32'h5000_0000, 1'b0, 64'd0, 3'd3, 5'd9));
        stim_q.push_back(mk(32'h5000_0008, 1'b0, 64'd0, 3'd3, 5'd10));
        repeat (8) step();
        chk("t6_outstanding", 64'(kl_pend_q.size()), 64'd2);
        do_reset();
        resp_en = 1'b1;
        t0 = n_tx_hs; k0 = n_kl_hs;
        repeat (10) step();
        chk("t6_no_stale_tx", 64'(n_tx_hs - t0), 64'd0);
        chk("t6_no_stale_kl", 64'(n_kl_hs - k0), 64'd0);
        stim_q.push_back(mk(32'h6000_0004, 1'b0, 64'd0, 3'd1, 5'd11));
        drain("t6_drain", 50);
        chk("t6_id", 64'(last_tx_id), 64'd11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
